pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the datapath payload (operands, immediate, PC).
REQ-002 SHALL have parameter CTRL_W, default 16, width of the control payload (RegWrite, MemRead, ALU op, etc.).
REQ-003 SHALL have parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, upstream stage offers a beat.
REQ-007 SHALL have port in_ready, output, 1, stage can accept a beat this cycle.
REQ-008 SHALL have port in_ctrl, input, CTRL_W, control payload of the offered beat.
REQ-009 SHALL have port in_data, input, DATA_W, data payload of the offered beat.
REQ-010 SHALL have port out_valid, output, 1, stage presents a beat downstream.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the presented beat.
REQ-012 SHALL have port out_ctrl, output, CTRL_W, control payload presented.
REQ-013 SHALL have port out_data, output, DATA_W, data payload presented.
REQ-014 SHALL have port flush, input, 1, synchronous kill of all held beats (branch/hazard bubble).
REQ-015 SHALL have port occupancy, output, 2, number of held beats (0..2).
REQ-016 SHALL have port stall_cnt, output, CNT_W, cycles with out_valid=1 and out_ready=0.

Function
REQ-017 SHALL hold a main register (drives outputs) and one skid register; states EMPTY (0 beats), ONE (main), FULL (main+skid).
REQ-018 SHALL drive in_ready = 1 iff state != FULL, from registered state only (no combinational path from out_ready).
REQ-019 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-020 SHALL transition EMPTY+push -> ONE, beat into main; out_valid rises the cycle after acceptance (latency 1).
REQ-021 SHALL transition ONE+push+pop -> ONE, main <= input beat; ONE+push only -> FULL, skid <= input beat; ONE+pop only -> EMPTY.
REQ-022 SHALL transition FULL+pop -> ONE, main <= skid; FULL without pop holds both registers unchanged.
REQ-023 SHALL deliver beats strictly in acceptance order, none duplicated or dropped absent flush.
REQ-024 SHALL drive out_valid = 1 iff state != EMPTY; occupancy equals 0/1/2 for EMPTY/ONE/FULL.
REQ-025 SHALL force out_ctrl to all zeros whenever out_valid=0 (bubble = NOP control); out_data holds its last value.
REQ-026 SHALL on flush=1 go to EMPTY at the next edge regardless of push/pop, discarding any beat pushed that same cycle; flush has priority over all transitions.
REQ-027 SHALL increment stall_cnt on each edge where out_valid=1 and out_ready=0, saturating at all ones; flush does not clear it.

Reset
REQ-028 SHALL on rst_n=0 immediately (without clock) set state EMPTY, main, skid and stall_cnt to zero.
REQ-029 SHALL present out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0, in_ready=1 while rst_n=0 and after release until first push.
REQ-030 SHALL, if reset asserts mid-transfer, discard all held beats; the first beat after release behaves as from EMPTY.

Verification
REQ-031 SHALL verify streaming: out_ready=1, push ctrl 0x0001..0x0005, data 0xA0..0xA4 back-to-back -> outputs appear one cycle later in order, occupancy stays 1, in_ready stays 1.
REQ-032 SHALL verify backpressure: out_ready=0, push 0x11 then 0x22 -> occupancy 2, in_ready=0, 0x33 held off; release out_ready -> 0x11, 0x22, 0x33 in order.
REQ-033 SHALL verify flush: FULL with 0x11/0x22, flush=1 with in_valid=1 (0x33) -> next cycle out_valid=0, out_ctrl=0, occupancy 0, 0x33 never emerges.
REQ-034 SHALL verify stall counter: out_valid=1, out_ready=0 for 7 cycles -> stall_cnt=7; with CNT_W=3 and 10 cycles -> stall_cnt=7 (saturated).
REQ-035 SHALL verify async reset: assert rst_n=0 between clock edges in FULL -> outputs zero and in_ready=1 before next rising edge.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with one skid slot: registered ready, in-order delivery,
// synchronous flush to a bubble, and a saturating downstream-stall counter.
module pipe_skid_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // The state encoding doubles as the held-beat count, so occupancy exposes the FSM state.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              push;
    logic              pop;

    // A beat moves on a side only in a cycle where both valid and ready are high on that side;
    // valid never depends on ready, and in_ready is a function of registered state alone.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign out_data  = main_data_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        stall_cnt_d = stall_cnt_q;

        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        if (flush) begin
            // Registers keep their contents so out_data holds; only the state is killed.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (push) begin
                        state_d     = ST_FULL;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: vector table plus hand-written flush, stall and reset
// sequences, with a queue-based scoreboard of accepted beats.
module tb_pipe_skid_stage;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 16;
    localparam int PW     = CTRL_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    logic              s_in_ready, s_out_valid;
    logic [CTRL_W-1:0] s_out_ctrl;
    logic [DATA_W-1:0] s_out_data;
    logic [1:0]        s_occupancy;
    logic [2:0]        s_stall_cnt;

    pipe_skid_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .flush(flush), .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    pipe_skid_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_ctrl(s_out_ctrl), .out_data(s_out_data), .flush(flush), .occupancy(s_occupancy),
        .stall_cnt(s_stall_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [PW-1:0]     exp_q[$];
    logic [DATA_W-1:0] last_data;
    int                stall_m;
    int                stall3_m;
    int                n_pass;
    int                n_total;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_data = '0;
        stall_m   = 0;
        stall3_m  = 0;
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl,
                         input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_ctrl   = c;
        in_data   = d;
    endtask

    // One cycle: compare against the model at the falling edge, advance the model, then
    // return just after the next rising edge so the caller can drive new inputs.
    task automatic step();
        logic [PW-1:0] head;
        int            occ;
        logic          p, q;
        @(negedge clk);
        occ  = exp_q.size();
        head = (occ != 0) ? exp_q[0] : '0;
        chk("in_ready", in_ready, occ != 2);
        chk("out_valid", out_valid, occ != 0);
        chk("occupancy", occupancy, occ);
        chk("out_ctrl", out_ctrl, (occ != 0) ? head[PW-1:DATA_W] : '0);
        chk("out_data", out_data, (occ != 0) ? head[DATA_W-1:0] : last_data);
        chk("stall_cnt", stall_cnt, stall_m);
        chk("stall_cnt_sat", s_stall_cnt, stall3_m);
        p = in_valid && (occ != 2);
        q = (occ != 0) && out_ready;
        if (occ != 0 && !out_ready) begin
            if (stall_m < 65535) stall_m++;
            if (stall3_m < 7) stall3_m++;
        end
        if (flush) begin
            exp_q.delete();
        end else begin
            if (q) void'(exp_q.pop_front());
            if (p) exp_q.push_back({in_ctrl, in_data});
        end
        if (exp_q.size() != 0) last_data = exp_q[0][DATA_W-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_ctrl"}, out_ctrl, '0);
        chk({tag, "_out_data"}, out_data, '0);
        chk({tag, "_occupancy"}, occupancy, 2'd0);
        chk({tag, "_stall_cnt"}, stall_cnt, '0);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic              iv;
        logic              ordy;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic [1:0]        exp_occ;
        logic              exp_in_ready;
    } vec_t;

    vec_t vecs[15];

    initial begin
        n_pass  = 0;
        n_total = 0;
        model_reset();

        // Streaming, then backpressure with 0x33 held off until the skid drains.
        vecs[0]  = '{1'b1, 1'b1, 16'h0001, 32'hA0, 2'd0, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 16'h0002, 32'hA1, 2'd1, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 16'h0003, 32'hA2, 2'd1, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 16'h0004, 32'hA3, 2'd1, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 16'h0005, 32'hA4, 2'd1, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 16'h0000, 32'h00, 2'd1, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 16'h0000, 32'h00, 2'd0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 16'h0011, 32'hB1, 2'd0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 16'h0022, 32'hB2, 2'd1, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 16'h0033, 32'hB3, 2'd2, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 16'h0033, 32'hB3, 2'd2, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 16'h0033, 32'hB3, 2'd2, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 16'h0033, 32'hB3, 2'd1, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 16'h0000, 32'h00, 2'd1, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 16'h0000, 32'h00, 2'd0, 1'b1};

        // Power-on reset, checked while asserted and right after release.
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        #12;
        reset_checks("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        reset_checks("post_por");

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].iv, vecs[i].ordy, 1'b0, vecs[i].ctrl, vecs[i].data);
            chk($sformatf("vec%0d_occ", i), occupancy, vecs[i].exp_occ);
            chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_in_ready);
            step();
        end
        chk("table_drained", exp_q.size(), 0);

        // Flush while FULL, with a simultaneous offer that must be discarded.
        drive(1'b1, 1'b0, 1'b0, 16'h0011, 32'hC1);
        step();
        drive(1'b1, 1'b0, 1'b0, 16'h0022, 32'hC2);
        step();
        chk("pre_flush_occ", occupancy, 2'd2);
        drive(1'b1, 1'b0, 1'b1, 16'h0033, 32'hC3);
        step();
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_out_ctrl", out_ctrl, '0);
        chk("flush_occ", occupancy, 2'd0);
        chk("flush_data_holds", out_data, 32'hC1);
        for (int i = 0; i < 3; i++) step();

        // Stall counter: 7 stalled edges, then 3 more to saturate the 3-bit instance.
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 16'h0044, 32'hD4);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 7; i++) step();
        chk("stall_7", stall_cnt, 16'd7);
        chk("stall_7_sat", s_stall_cnt, 3'd7);
        for (int i = 0; i < 3; i++) step();
        chk("stall_10", stall_cnt, 16'd10);
        chk("stall_10_sat", s_stall_cnt, 3'd7);

        // Async reset between edges while FULL.
        drive(1'b1, 1'b0, 1'b0, 16'h0055, 32'hE5);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        chk("pre_reset_occ", occupancy, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First beat after reset behaves as from EMPTY.
        drive(1'b1, 1'b1, 1'b0, 16'h0066, 32'hF6);
        step();
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 2; i++) step();
        chk("final_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
